ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//   Execute stage of the pipelined RV32I core. Consumes the 4-bit ALUinput code from ALU control.
//   Forwards operands, evaluates the ALU, resolves conditional branches and captures the results
//   in the EX/MEM pipeline register. Supports stall (hold) and flush (bubble) from hazard control.
// PARAMETERS
//   XLEN  32  datapath width; shift amount is always operand B[4:0]
// PORTS
//   clk              in   1     single clock; all state updates on rising edge
//   reset            in   1     synchronous, active-high
//   stall            in   1     1 = hold EX/MEM register contents
//   flush            in   1     1 = load a bubble into EX/MEM
//   in_valid         in   1     ID/EX holds a real instruction
//   ALUinput         in   4     operation code from ALU control
//   funct3           in   3     branch condition select
//   Branch           in   1     instruction is a conditional branch
//   ALUsrc           in   1     0 = operand B is forwarded rs2; 1 = operand B is imm
//   rs1_data         in   XLEN  register-file rs1 value
//   rs2_data         in   XLEN  register-file rs2 value
//   imm              in   XLEN  sign-extended immediate
//   fwdA, fwdB       in   2     00 = regfile, 10 = exmem_fwd, 01 = memwb_fwd, 11 = regfile
//   exmem_fwd        in   XLEN  forwarded EX/MEM result
//   memwb_fwd        in   XLEN  forwarded MEM/WB result
//   rd_in            in   5     destination register
//   RegWrite_in      in   1     control bit, passed through to EX/MEM
//   MemRead_in       in   1     control bit, passed through to EX/MEM
//   MemWrite_in      in   1     control bit, passed through to EX/MEM
//   out_valid        out  1     EX/MEM holds a real instruction
//   alu_result       out  XLEN  registered ALU result
//   store_data       out  XLEN  registered forwarded rs2 (independent of ALUsrc)
//   rd_out           out  5     registered rd_in
//   RegWrite_out     out  1     registered RegWrite_in
//   MemRead_out      out  1     registered MemRead_in
//   MemWrite_out     out  1     registered MemWrite_in
//   branch_taken     out  1     registered branch decision
// BEHAVIOUR
//   ALU codes (A, B after forwarding/muxing):
//     0000 AND   0001 OR    0010 ADD (mod 2^XLEN)  0011 XOR   0100 SLL
//     0101 SRL   0110 SUB   0111 SLTU (zero-extended 0/1)      1000 SLT (signed)
//     1001 SRA (arithmetic)
//     Any other code or X: result = 0; no X propagation.
//   zero = (result == 0).
//   Branch decision (only when Branch=1 and in_valid=1; otherwise 0):
//     funct3 000 beq = zero       001 bne = !zero
//     100 blt = result[0]         101 bge = !result[0]
//     110 bltu = result[0]        111 bgeu = !result[0]
//     other funct3 values = 0
//   Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
//   Register update priority:
//     reset > flush > stall > load.
//   reset: all outputs = 0, including data fields.
//   flush: out_valid, RegWrite_out, MemRead_out, MemWrite_out, branch_taken = 0;
//     data fields are don't-care. Flush with stall asserted still inserts the bubble.
//   stall (no flush): every output holds its value, including branch_taken.
//   in_valid=0 at load: same bubble as flush; control bits must never leak from an invalid slot.
//   Forwarding mux and ALU are purely combinational; no combinational path from inputs to outputs.
// STRUCTURE
//   riscv_pkg: ALU op localparams (ALU_AND..ALU_SRA), FWD_* select encodings, BR_* funct3 constants.
//   Sub-module alu_core (combinational):
//     inputs A, B, ALUinput; outputs result, zero.
//   ex_stage instantiates alu_core and owns the forwarding muxes, branch logic and EX/MEM register.
// TESTING
//   1. ADD, A=0x7FFFFFFF, B=1 -> alu_result 0x80000000 one cycle later; out_valid=1.
//   2. SRA, A=0x80000010, imm=0x24, ALUsrc=1 (shamt 4) -> 0xF8000001.
//      Same operands with SRL -> 0x08000001.
//   3. Branch, SUB, funct3=000, A=B=5 -> branch_taken=1.
//      Same setup with SLT, funct3=101 (bge), A=-1, B=1 -> branch_taken=0.
//   4. fwdA=10, exmem_fwd=0x10, rs1_data=0x99, B=imm=4, ADD -> 0x14.
//      fwdB=01 with ALUsrc=0 -> store_data = memwb_fwd.
//   5. Load RegWrite_in=1, then assert stall for 3 cycles with new inputs -> outputs unchanged.
//      Then stall+flush -> RegWrite_out=0, out_valid=0.
//   6. Assert reset mid-stream with valid inputs -> all outputs 0 after the edge.
//      Illegal ALUinput 1111 -> alu_result 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the RV32I execute stage:
//   - ALU_*  : 4-bit ALU operation codes produced by ALU control
//   - FWD_*  : 2-bit operand forwarding selects from the hazard unit
//   - BR_*   : funct3 encodings of the conditional branches
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // 2'b11 is unused by the hazard unit and falls back to the register file.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage : riscv_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational RV32I ALU.
// Ports:
//   a_i       in   XLEN  operand A (after forwarding)
//   b_i       in   XLEN  operand B (after forwarding / immediate select)
//   alu_op_i  in   4     operation code (riscv_pkg::ALU_*)
//   result_o  out  XLEN  operation result; 0 for any unrecognised code
//   zero_o    out  1     result_o == 0
// -----------------------------------------------------------------------------
module alu_core
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      alu_op_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    // Shift amount always comes from the low five bits of B, for both
    // register and immediate shifts.
    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        // NOTE: default assignment first so every path drives result_o;
        // without it an incomplete case infers a latch. It also maps illegal
        // or unknown op codes to 0 instead of letting X escape.
        result_o = '0;
        case (alu_op_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule : alu_core

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the pipelined RV32I core: operand forwarding, ALU, branch
// resolution and the EX/MEM pipeline register (1-cycle latency).
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   stall / flush               hold EX/MEM / load a bubble into EX/MEM
//   in_valid                    ID/EX slot holds a real instruction
//   ALUinput, funct3, Branch    ALU op, branch condition, branch flag
//   ALUsrc                      0 = B is forwarded rs2, 1 = B is imm
//   rs1_data, rs2_data, imm     register-file operands and immediate
//   fwdA, fwdB                  forwarding selects (riscv_pkg::FWD_*)
//   exmem_fwd, memwb_fwd        forwarded results from later stages
//   rd_in, *_in                 destination and control bits to pass on
//   out_valid .. branch_taken   registered EX/MEM contents
// -----------------------------------------------------------------------------
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [3:0]      ALUinput,
    input  logic [2:0]      funct3,
    input  logic            Branch,
    input  logic            ALUsrc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      fwdA,
    input  logic [1:0]      fwdB,
    input  logic [XLEN-1:0] exmem_fwd,
    input  logic [XLEN-1:0] memwb_fwd,
    input  logic [4:0]      rd_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            RegWrite_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            branch_taken
);

    // ---------------------------------------------------------------- operands
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op_b;

    always_comb begin
        op_a = rs1_data;
        case (fwdA)
            FWD_EXMEM: op_a = exmem_fwd;
            FWD_MEMWB: op_a = memwb_fwd;
            default:   op_a = rs1_data;
        endcase
    end

    always_comb begin
        rs2_fwd = rs2_data;
        case (fwdB)
            FWD_EXMEM: rs2_fwd = exmem_fwd;
            FWD_MEMWB: rs2_fwd = memwb_fwd;
            default:   rs2_fwd = rs2_data;
        endcase
    end

    // Store data is always the forwarded rs2, even when B takes the immediate.
    assign op_b = ALUsrc ? imm : rs2_fwd;

    // --------------------------------------------------------------------- ALU
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;

    alu_core #(.XLEN(XLEN)) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .alu_op_i (ALUinput),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // ------------------------------------------------------------------ branch
    // Signed/unsigned compares rely on ALU control selecting SLT/SLTU, so
    // result bit 0 carries the comparison outcome.
    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        if (Branch && in_valid) begin
            case (funct3)
                BR_BEQ:  br_cond =  alu_zero;
                BR_BNE:  br_cond = !alu_zero;
                BR_BLT:  br_cond =  alu_res[0];
                BR_BGE:  br_cond = !alu_res[0];
                BR_BLTU: br_cond =  alu_res[0];
                BR_BGEU: br_cond = !alu_res[0];
                default: br_cond = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------ EX/MEM next state
    logic            valid_q,    valid_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic [XLEN-1:0] store_q,    store_d;
    logic [4:0]      rd_q,       rd_d;
    logic            regwr_q,    regwr_d;
    logic            memrd_q,    memrd_d;
    logic            memwr_q,    memwr_d;
    logic            taken_q,    taken_d;

    // Priority below reset: flush > stall > load. Data fields simply hold on
    // a flush; only the control bits need to be cleared for a bubble.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        regwr_d  = regwr_q;
        memrd_d  = memrd_q;
        memwr_d  = memwr_q;
        taken_d  = taken_q;
        if (flush) begin
            valid_d = 1'b0;
            regwr_d = 1'b0;
            memrd_d = 1'b0;
            memwr_d = 1'b0;
            taken_d = 1'b0;
        end else if (!stall) begin
            valid_d  = in_valid;
            result_d = alu_res;
            store_d  = rs2_fwd;
            rd_d     = rd_in;
            // An invalid slot becomes a bubble: no control bit may leak.
            regwr_d  = RegWrite_in & in_valid;
            memrd_d  = MemRead_in  & in_valid;
            memwr_d  = MemWrite_in & in_valid;
            taken_d  = br_cond;
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            regwr_q  <= 1'b0;
            memrd_q  <= 1'b0;
            memwr_q  <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            regwr_q  <= regwr_d;
            memrd_q  <= memrd_d;
            memwr_q  <= memwr_d;
            taken_q  <= taken_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_result   = result_q;
    assign store_data   = store_q;
    assign rd_out       = rd_q;
    assign RegWrite_out = regwr_q;
    assign MemRead_out  = memrd_q;
    assign MemWrite_out = memwr_q;
    assign branch_taken = taken_q;

endmodule : ex_stage

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage: a table of vectors applied back to back,
// plus hand-written stall / flush / reset sequences. Expected EX/MEM contents
// are pushed to a scoreboard queue when stimulus is driven and popped after
// the following rising edge.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [3:0]      ALUinput;
    logic [2:0]      funct3;
    logic            Branch;
    logic            ALUsrc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [1:0]      fwdA;
    logic [1:0]      fwdB;
    logic [XLEN-1:0] exmem_fwd;
    logic [XLEN-1:0] memwb_fwd;
    logic [4:0]      rd_in;
    logic            RegWrite_in;
    logic            MemRead_in;
    logic            MemWrite_in;
    logic            out_valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd_out;
    logic            RegWrite_out;
    logic            MemRead_out;
    logic            MemWrite_out;
    logic            branch_taken;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .ALUinput     (ALUinput),
        .funct3       (funct3),
        .Branch       (Branch),
        .ALUsrc       (ALUsrc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .exmem_fwd    (exmem_fwd),
        .memwb_fwd    (memwb_fwd),
        .rd_in        (rd_in),
        .RegWrite_in  (RegWrite_in),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .out_valid    (out_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_out       (rd_out),
        .RegWrite_out (RegWrite_out),
        .MemRead_out  (MemRead_out),
        .MemWrite_out (MemWrite_out),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ types
    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        br;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] im;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exf;
        logic [31:0] mwf;
        logic        v;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] e_res;
        logic [31:0] e_sd;
        logic        e_bt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        bt;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------------------------------------------------------- helpers
    function automatic vec_t mkv(input logic [3:0] op, input logic [2:0] f3,
                                 input logic br, input logic src,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] im, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic [31:0] exf,
                                 input logic [31:0] mwf, input logic v,
                                 input logic [31:0] e_res, input logic [31:0] e_sd,
                                 input logic e_bt);
        vec_t t;
        t.op = op;   t.f3 = f3;   t.br = br;   t.src = src;
        t.rs1 = rs1; t.rs2 = rs2; t.im = im;   t.fa = fa;  t.fb = fb;
        t.exf = exf; t.mwf = mwf; t.v = v;
        t.rd = 5'd0; t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.e_res = e_res; t.e_sd = e_sd; t.e_bt = e_bt;
        return t;
    endfunction

    function automatic exp_t mke(input logic valid, input logic [31:0] res,
                                 input logic [31:0] sd, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic bt, input logic chk_data);
        exp_t e;
        e.valid = valid; e.res = res; e.sd = sd; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.bt = bt; e.chk_data = chk_data;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        ALUinput    = t.op;
        funct3      = t.f3;
        Branch      = t.br;
        ALUsrc      = t.src;
        rs1_data    = t.rs1;
        rs2_data    = t.rs2;
        imm         = t.im;
        fwdA        = t.fa;
        fwdB        = t.fb;
        exmem_fwd   = t.exf;
        memwb_fwd   = t.mwf;
        in_valid    = t.v;
        rd_in       = t.rd;
        RegWrite_in = t.rw;
        MemRead_in  = t.mr;
        MemWrite_in = t.mw;
    endtask

    // Advance one clock and compare the DUT against the oldest expectation.
    task automatic step_and_compare(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.scoreboard: got 0 entries expected at least 1", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".out_valid"},    32'(out_valid),    32'(e.valid));
        check({tag, ".RegWrite_out"}, 32'(RegWrite_out), 32'(e.rw));
        check({tag, ".MemRead_out"},  32'(MemRead_out),  32'(e.mr));
        check({tag, ".MemWrite_out"}, 32'(MemWrite_out), 32'(e.mw));
        check({tag, ".branch_taken"}, 32'(branch_taken), 32'(e.bt));
        if (e.chk_data) begin
            check({tag, ".alu_result"}, alu_result,     e.res);
            check({tag, ".store_data"}, store_data,     e.sd);
            check({tag, ".rd_out"},     32'(rd_out),    32'(e.rd));
        end
    endtask

    // ------------------------------------------------------------------- test
    vec_t t;
    vec_t held;

    initial begin
        // Idle inputs, reset asserted.
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        apply(mkv(ALU_ADD, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00,
                  32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        sb.push_back(mke(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step_and_compare("reset");
        reset = 1'b0;

        // op, f3, br, src, rs1, rs2, imm, fa, fb, exf, mwf, v, e_res, e_sd, e_bt
        vecs.push_back(mkv(ALU_ADD,  3'b000, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h80000000, 32'h1, 0));
        vecs.push_back(mkv(ALU_SRA,  3'b000, 0, 1, 32'h80000010, 32'h55, 32'h24, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'hF8000001, 32'h55, 0));
        vecs.push_back(mkv(ALU_SRL,  3'b000, 0, 1, 32'h80000010, 32'h55, 32'h24, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h08000001, 32'h55, 0));
        vecs.push_back(mkv(ALU_SUB,  BR_BEQ, 1, 0, 32'h5, 32'h5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'h5, 1));
        vecs.push_back(mkv(ALU_SLT,  BR_BGE, 1, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h1, 32'h1, 0));
        vecs.push_back(mkv(ALU_ADD,  3'b000, 0, 1, 32'h99, 32'h7, 32'h4, 2'b10, 2'b00, 32'h10, 32'h0, 1, 32'h14, 32'h7, 0));
        vecs.push_back(mkv(ALU_ADD,  3'b000, 0, 0, 32'h1, 32'h9, 32'h0, 2'b00, 2'b01, 32'h0, 32'h1234, 1, 32'h1235, 32'h1234, 0));
        vecs.push_back(mkv(4'b1111,  3'b000, 0, 0, 32'h3, 32'h4, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'h4, 0));
        vecs.push_back(mkv(ALU_AND,  3'b000, 0, 0, 32'hF0F0, 32'hFF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'hF000, 32'hFF00, 0));
        vecs.push_back(mkv(ALU_OR,   3'b000, 0, 0, 32'hF0F0, 32'hFF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'hFFF0, 32'hFF00, 0));
        vecs.push_back(mkv(ALU_XOR,  3'b000, 0, 0, 32'hF0F0, 32'hFF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0FF0, 32'hFF00, 0));
        vecs.push_back(mkv(ALU_SLL,  3'b000, 0, 0, 32'h1, 32'h21, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h2, 32'h21, 0));
        vecs.push_back(mkv(ALU_SLTU, BR_BLTU, 1, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h1, 32'hFFFFFFFF, 1));
        vecs.push_back(mkv(ALU_SLTU, BR_BGEU, 1, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'h1, 1));
        vecs.push_back(mkv(ALU_SUB,  BR_BNE, 1, 0, 32'h5, 32'h3, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h2, 32'h3, 1));
        vecs.push_back(mkv(ALU_SUB,  BR_BEQ, 1, 0, 32'h5, 32'h5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mkv(ALU_ADD,  3'b000, 0, 0, 32'h20, 32'h1, 32'h0, 2'b11, 2'b00, 32'hDEAD, 32'h0, 1, 32'h21, 32'h1, 0));
        vecs.push_back(mkv(ALU_SUB,  3'b010, 1, 0, 32'h5, 32'h5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'h5, 0));
        vecs.push_back(mkv(ALU_SUB,  3'b000, 0, 0, 32'h0, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 32'h1, 0));
        vecs.push_back(mkv(ALU_SUB,  BR_BEQ, 0, 0, 32'h5, 32'h5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'h5, 0));
        vecs.push_back(mkv(ALU_SLT,  BR_BLT, 1, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0, 32'hFFFFFFFF, 0));
        vecs.push_back(mkv(ALU_SRA,  3'b000, 0, 0, 32'h80000000, 32'h3F, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 32'h3F, 0));
        vecs.push_back(mkv(ALU_ADD,  3'b000, 0, 0, 32'h1, 32'h5, 32'h0, 2'b00, 2'b10, 32'h100, 32'h0, 1, 32'h101, 32'h100, 0));
        vecs.push_back(mkv(ALU_SUB,  3'b000, 0, 0, 32'h77, 32'h5, 32'h0, 2'b01, 2'b00, 32'h0, 32'h50, 1, 32'h4B, 32'h5, 0));

        // Back-to-back table vectors; rd and control bits vary with the index.
        for (int i = 0; i < vecs.size(); i++) begin
            t    = vecs[i];
            t.rd = 5'(i + 1);
            t.rw = i[0];
            t.mr = i[1];
            t.mw = i[2];
            apply(t);
            sb.push_back(mke(t.v, t.e_res, t.e_sd, t.rd,
                             t.rw & t.v, t.mr & t.v, t.mw & t.v, t.e_bt, t.v));
            step_and_compare($sformatf("vec%0d", i));
        end

        // Load a taken branch with RegWrite/MemWrite set, then stall 3 cycles
        // with different inputs: everything must hold.
        held = mkv(ALU_SUB, BR_BEQ, 1, 0, 32'h5, 32'h5, 32'h0, 2'b00, 2'b00,
                   32'h0, 32'h0, 1, 32'h0, 32'h5, 1);
        held.rd = 5'd7; held.rw = 1'b1; held.mw = 1'b1;
        apply(held);
        sb.push_back(mke(1'b1, 32'h0, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        step_and_compare("stall_load");

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = mkv(ALU_ADD, BR_BNE, 1, 0, 32'(i + 1), 32'h2, 32'h0, 2'b00, 2'b00,
                    32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
            t.rd = 5'd3; t.mr = 1'b1;
            apply(t);
            sb.push_back(mke(1'b1, 32'h0, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
            step_and_compare($sformatf("stall%0d", i));
        end

        // Flush wins over stall.
        flush = 1'b1;
        sb.push_back(mke(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step_and_compare("stall_flush");
        stall = 1'b0;
        flush = 1'b0;

        // Resume after the bubble.
        t = mkv(ALU_ADD, 3'b000, 0, 0, 32'h1, 32'h2, 32'h0, 2'b00, 2'b00,
                32'h0, 32'h0, 1, 32'h3, 32'h2, 0);
        t.rd = 5'd3; t.mr = 1'b1;
        apply(t);
        sb.push_back(mke(1'b1, 32'h3, 32'h2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        step_and_compare("resume");

        // Flush alone on a valid taken branch: bubble, no branch, no writes.
        apply(held);
        flush = 1'b1;
        sb.push_back(mke(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step_and_compare("flush_only");
        flush = 1'b0;

        // Reload, then reset mid-stream with valid inputs present.
        apply(held);
        sb.push_back(mke(1'b1, 32'h0, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        step_and_compare("pre_reset");
        t = mkv(ALU_ADD, 3'b000, 0, 0, 32'h11, 32'h22, 32'h0, 2'b00, 2'b00,
                32'h0, 32'h0, 1, 32'h33, 32'h22, 0);
        t.rd = 5'd9; t.rw = 1'b1; t.mr = 1'b1;
        apply(t);
        reset = 1'b1;
        sb.push_back(mke(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step_and_compare("mid_reset");
        reset = 1'b0;

        // Same instruction after reset releases loads normally.
        sb.push_back(mke(1'b1, 32'h33, 32'h22, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        step_and_compare("post_reset");

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ex_stage
